// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm sounder sequencer (ports: clk256, reset, one_second, key, alarm_enable, current_time, alarm_time -> buzzer, ringing, snooze_active, snooze_count)
module alarm_ring_ctrl #(
  parameter int          RING_SECS   = 60,
  parameter int          SNOOZE_SECS = 540,
  parameter int          MAX_SNOOZE  = 3,
  parameter logic [7:0]  SNOOZE_KEY  = 8'h79,
  parameter logic [7:0]  STOP_KEY    = 8'h5A
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic        one_second,
  input  logic [7:0]  key,
  input  logic        alarm_enable,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  output logic        buzzer,
  output logic        ringing,
  output logic        snooze_active,
  output logic [2:0]  snooze_count
);
  typedef enum logic [2:0] {DISARMED, ARMED, RINGING, SNOOZE, HOLDOFF} state_t;
  state_t state, state_n;
  logic [9:0] ring_cnt, ring_cnt_n, snooze_cnt, snooze_cnt_n;
  logic [2:0] snooze_count_n;
  logic       beep_phase, beep_n, match, match_q, press, snooze_press, stop_press;
  logic [7:0] key_q;
  assign match        = current_time == alarm_time;
  // a byte directly after the F0 prefix is a release code and never counts as a press
  assign press        = (key != key_q) && (key_q != 8'hF0);
  assign snooze_press = press && key == SNOOZE_KEY;
  assign stop_press   = press && key == STOP_KEY;
  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state        <= DISARMED;
      ring_cnt     <= '0;
      snooze_cnt   <= '0;
      snooze_count <= '0;
      beep_phase   <= 1'b0;
      key_q        <= 8'h00;
      match_q      <= 1'b0;
    end else begin
      state        <= state_n;
      ring_cnt     <= ring_cnt_n;
      snooze_cnt   <= snooze_cnt_n;
      snooze_count <= snooze_count_n;
      beep_phase   <= beep_n;
      key_q        <= key;
      match_q      <= match;
    end
  end
  // a recognised key press in the same cycle as one_second swallows the tick
  always_comb begin
    state_n        = state;
    ring_cnt_n     = ring_cnt;
    snooze_cnt_n   = snooze_cnt;
    snooze_count_n = snooze_count;
    beep_n         = beep_phase;
    if (!alarm_enable) begin
      state_n        = DISARMED;
      ring_cnt_n     = '0;
      snooze_cnt_n   = '0;
      snooze_count_n = '0;
      beep_n         = 1'b0;
    end else begin
      case (state)
        DISARMED: state_n = HOLDOFF;
        ARMED: if (match && !match_q) begin
          state_n        = RINGING;
          ring_cnt_n     = 10'(RING_SECS);
          beep_n         = 1'b1;
          snooze_count_n = '0;
        end
        RINGING: if (stop_press) state_n = HOLDOFF;
        else if (snooze_press) begin
          if (snooze_count < 3'(MAX_SNOOZE)) begin
            state_n        = SNOOZE;
            snooze_cnt_n   = 10'(SNOOZE_SECS);
            snooze_count_n = snooze_count + 3'd1;
          end
        end else if (one_second) begin
          beep_n = !beep_phase;
          if (ring_cnt == 10'd1) state_n = HOLDOFF;
          else ring_cnt_n = ring_cnt - 10'd1;
        end
        SNOOZE: if (stop_press) state_n = HOLDOFF;
        else if (one_second && !snooze_press) begin
          if (snooze_cnt == 10'd1) begin
            state_n    = RINGING;
            ring_cnt_n = 10'(RING_SECS);
            beep_n     = 1'b1;
          end else snooze_cnt_n = snooze_cnt - 10'd1;
        end
        HOLDOFF: state_n = match ? HOLDOFF : ARMED;
        default: state_n = DISARMED;
      endcase
    end
  end
  always_comb begin
    ringing       = state == RINGING;
    snooze_active = state == SNOOZE;
    buzzer        = ringing && beep_phase;
  end
endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Sequences the alarm sounder for the alarm clock.
- Compares current time against the stored alarm time and starts ringing on a match.
- Times the ring and snooze intervals from the one_second tick.
- Handles snooze/stop keypad presses and suppresses re-triggering within the matching minute.
- Sits beside the top alarm controller; shares its key bus and one_second pulse, and drives the speaker/LED path.

Parameters:
RING_SECS, 60, seconds of ringing before auto-stop (1..1023)
SNOOZE_SECS, 540, seconds of snooze before re-ring (1..1023)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)
SNOOZE_KEY, 8'h79, PS/2 set-2 make code for snooze (keypad +)
STOP_KEY, 8'h5A, PS/2 set-2 make code for stop (Enter)

Ports:
clk256  in  1  system clock, 256 Hz
reset  in  1  asynchronous, active-high reset
one_second  in  1  one-clk256-cycle pulse, once per second
key  in  8  latest keypad byte; 8'hF0 = release prefix; 8'h00 = idle/invalid
alarm_enable  in  1  alarm armed switch (level)
current_time  in  16  BCD HHMM of current time
alarm_time  in  16  BCD HHMM of stored alarm
buzzer  out  1  sounder drive, 1 s on / 1 s off while ringing
ringing  out  1  high in RINGING
snooze_active  out  1  high in SNOOZE
snooze_count  out  3  snoozes used in current alarm event

Behaviour:
- Reset (async, immediate):
  - state=DISARMED; ring_cnt, snooze_cnt, snooze_count = 0; beep_phase=0; key_q=8'h00; match_q=0.
  - All outputs 0.
- Synchronous logic on posedge clk256 only.
- match = (current_time == alarm_time), full 16-bit compare. match_q = match registered each cycle.
- Key press event:
  - Asserted when key != key_q and key_q != 8'hF0; key_q registered each cycle.
  - A byte following 8'hF0 is a release and is ignored.
  - Only SNOOZE_KEY and STOP_KEY have effect; all other codes are ignored.
- States: DISARMED, ARMED, RINGING, SNOOZE, HOLDOFF.
  - DISARMED: alarm_enable=1 -> HOLDOFF. Entering via HOLDOFF prevents ringing if enabled during the matching minute.
  - ARMED: match & !match_q (rising edge) -> RINGING. On entry to RINGING: ring_cnt=RING_SECS, beep_phase=1, snooze_count=0.
  - RINGING:
    - STOP press -> HOLDOFF.
    - SNOOZE press with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_cnt=SNOOZE_SECS, snooze_count+1.
    - SNOOZE press with snooze_count==MAX_SNOOZE -> ignored.
    - Otherwise on one_second: beep_phase toggles, ring_cnt decrements. If ring_cnt==1 at that tick -> HOLDOFF.
  - SNOOZE:
    - STOP press -> HOLDOFF.
    - On one_second: snooze_cnt decrements. If snooze_cnt==1 -> RINGING; ring_cnt reloaded, beep_phase=1, snooze_count kept. Re-ring does not depend on match.
  - HOLDOFF: match==0 -> ARMED. Stop inside the matching minute therefore does not re-trigger.
  - Any state except DISARMED: alarm_enable=0 -> DISARMED next edge. This has priority over all other transitions; counters and snooze_count clear.
- Priority within one cycle: disable > key press > one_second. When a key press and one_second coincide, the tick is discarded.
- Outputs are decoded from the state register and registered counters, so they change on the same edge as the state (no extra latency):
  - ringing = (state==RINGING)
  - buzzer = ringing & beep_phase
  - snooze_active = (state==SNOOZE)
- Ring duration is exactly RING_SECS one_second pulses after entry. Snooze duration is exactly SNOOZE_SECS pulses.
- Counters are 10-bit unsigned and never decrement below 1. ring_cnt decrements only in RINGING; snooze_cnt only in SNOOZE.
- one_second wider than one cycle is out of contract.

Test Plan (RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2):
1. reset=1 mid-RINGING -> buzzer/ringing/snooze_active/snooze_count=0 before the next clk edge; after release with alarm_enable=1 and match held, state remains HOLDOFF with no ring.
2. ARMED, alarm_time=16'h0715, current_time steps 0714->0715 -> ringing=1 on the next edge, buzzer=1; buzzer toggles per one_second pulse; ringing falls on the 4th pulse; no re-ring while current_time stays 0715; after current_time becomes 0716 -> ARMED.
3. RINGING, key sequence 79, F0, 79, 00 -> SNOOZE once only (the release byte is ignored), snooze_count=1; ringing=1 again on the 3rd one_second pulse.
4. Snooze twice, then a third 79 press while ringing -> stays RINGING, snooze_count=2; key 5A -> HOLDOFF, buzzer=0 on the same edge.
5. SNOOZE with alarm_enable dropped in the same cycle as a one_second pulse and a 5A press -> DISARMED, snooze_count=0; re-enable with match=1 -> HOLDOFF, no ring until match clears and re-asserts.
6. RINGING with a 79 press and one_second in the same cycle -> SNOOZE, snooze_cnt=3, beep_phase unchanged by the dropped tick.
